// File: rtl/fp_int_mac_ctrl.sv
// Sequencer feeding (fp16 activation, int weight) elements bit-serially to an external MAC unit
// and chaining its exponent/accumulator between elements. Optional macro FP_INT_MAC_CTRL_TIMEOUT_EN.
module fp_int_mac_ctrl #(
  parameter int unsigned ACT_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [3:0]           cfg_precision,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [3:0]           in_w,
  output logic                 mac_valid,
  output logic                 mac_w,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic [3:0]           mac_precision,
  output logic [4:0]           mac_exp_set,
  output logic [31:0]          mac_acc,
  input  logic [4:0]           mac_exp_out,
  input  logic [31:0]          mac_acc_out,
  input  logic                 mac_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4:0]           res_exp,
  output logic [ACC_WIDTH-1:0] res_acc,
  output logic                 err
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StFeed = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StOut  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [3:0]           prec_q, prec_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic [3:0]           w_q, w_d;
  logic [1:0]           bit_cnt_q, bit_cnt_d;
  logic [4:0]           exp_q, exp_d;
  logic [31:0]          acc_q, acc_d;
  logic [3:0]           prec_eff;
  logic                 last_bit;

`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
  logic [5:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  // Out-of-range precision falls back to the full 4-bit weight.
  assign prec_eff = (cfg_precision >= 4'd1 && cfg_precision <= 4'd4) ? cfg_precision : 4'd4;
  assign last_bit = ({2'b00, bit_cnt_q} == (prec_q - 4'd1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    prec_d    = prec_q;
    act_d     = act_q;
    w_d       = w_q;
    bit_cnt_d = bit_cnt_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = cfg_len;
          prec_d  = prec_eff;
          exp_d   = '0;
          acc_d   = '0;
          state_d = (cfg_len == '0) ? StOut : StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          act_d     = in_act;
          w_d       = in_w;
          bit_cnt_d = '0;
          state_d   = StFeed;
        end
      end
      StFeed: begin
        if (last_bit) begin
          state_d = StWait;
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 2'd1;
        end
      end
      StWait: begin
        if (mac_done) begin
          exp_d   = mac_exp_out;
          acc_d   = mac_acc_out;
          len_d   = len_q - LEN_WIDTH'(1);
          state_d = (len_q == LEN_WIDTH'(1)) ? StOut : StLoad;
        end
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
        else if (wdog_q == 6'd63) begin
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          wdog_d = wdog_q + 6'd1;
        end
`endif
      end
      StOut: begin
        if (res_ready) begin
          state_d = StIdle;
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      prec_q    <= '0;
      act_q     <= '0;
      w_q       <= '0;
      bit_cnt_q <= '0;
      exp_q     <= '0;
      acc_q     <= '0;
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      prec_q    <= prec_d;
      act_q     <= act_d;
      w_q       <= w_d;
      bit_cnt_q <= bit_cnt_d;
      exp_q     <= exp_d;
      acc_q     <= acc_d;
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  assign busy          = (state_q != StIdle);
  assign in_ready      = (state_q == StLoad);
  assign mac_valid     = (state_q == StFeed);
  assign mac_w         = mac_valid & w_q[bit_cnt_q];
  assign mac_act       = act_q;
  assign mac_precision = prec_q;
  assign mac_exp_set   = exp_q;
  assign mac_acc       = acc_q;
  assign res_valid     = (state_q == StOut);
  assign res_exp       = exp_q;

`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  if (ACC_WIDTH > 32) begin : gen_acc_ext
    assign res_acc = {{(ACC_WIDTH - 32){1'b0}}, acc_q};
  end else begin : gen_acc_trunc
    assign res_acc = acc_q[ACC_WIDTH-1:0];
  end

endmodule

// File: tb/tb_fp_int_mac_ctrl.sv
// Directed bench for fp_int_mac_ctrl: table of single-element jobs plus hand sequences for
// chaining, result back-pressure, mid-job reset and the WAIT watchdog.
module tb_fp_int_mac_ctrl;
  localparam int ACT_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int LEN_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid, mac_done, res_ready;
  logic [LEN_WIDTH-1:0] cfg_len;
  logic [3:0]           cfg_precision, in_w, mac_precision;
  logic [ACT_WIDTH-1:0] in_act, mac_act;
  logic                 busy, in_ready, mac_valid, mac_w, res_valid, err;
  logic [4:0]           mac_exp_set, mac_exp_out, res_exp;
  logic [31:0]          mac_acc, mac_acc_out;
  logic [ACC_WIDTH-1:0] res_acc;

  fp_int_mac_ctrl #(
    .ACT_WIDTH(ACT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_precision(cfg_precision),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_act       (in_act),
    .in_w         (in_w),
    .mac_valid    (mac_valid),
    .mac_w        (mac_w),
    .mac_act      (mac_act),
    .mac_precision(mac_precision),
    .mac_exp_set  (mac_exp_set),
    .mac_acc      (mac_acc),
    .mac_exp_out  (mac_exp_out),
    .mac_acc_out  (mac_acc_out),
    .mac_done     (mac_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_exp      (res_exp),
    .res_acc      (res_acc),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  prec;
    logic [3:0]  w;
    logic [15:0] act;
    logic [3:0]  p_eff;
    int          n_valid;
    logic [3:0]  bits;
    logic [31:0] acc;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {busy, in_ready, mac_valid, mac_w, res_valid, err}, 6'b0);
    check({tag, "_mac_act"}, mac_act, 0);
    check({tag, "_mac_prec"}, mac_precision, 0);
    check({tag, "_mac_exp_set"}, mac_exp_set, 0);
    check({tag, "_mac_acc"}, mac_acc, 0);
    check({tag, "_res"}, {res_exp, res_acc}, 0);
  endtask

  task automatic run_single(input vec_t v);
    int         cnt;
    logic [3:0] bits;
    start = 1'b1; cfg_len = 8'd1; cfg_precision = v.prec;
    tick();
    start = 1'b0;
    check("load_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_act = v.act; in_w = v.w;
    tick();
    in_valid = 1'b0; in_act = '0; in_w = '0;
    cnt = 0;
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      if (mac_valid) begin
        if (cnt < 4) bits[cnt] = mac_w;
        if (cnt == 0) begin
          check("mac_act", mac_act, v.act);
          check("mac_precision", mac_precision, v.p_eff);
          check("first_exp_set", mac_exp_set, 0);
          check("first_mac_acc", mac_acc, 0);
        end
        cnt++;
      end
      tick();
    end
    check("mac_valid_cycles", cnt, v.n_valid);
    check("mac_w_bits", bits, v.bits);
    mac_done = 1'b1; mac_acc_out = v.acc; mac_exp_out = v.exp;
    tick();
    mac_done = 1'b0;
    check("single_res_valid", res_valid, 1'b1);
    check("single_res_acc", res_acc, v.acc);
    check("single_res_exp", res_exp, v.exp);
    check("single_err", err, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("single_idle", {busy, res_valid}, 2'b00);
  endtask

  initial begin
    logic [31:0] accs[3];
    logic [31:0] prev_acc;
    logic [4:0]  prev_exp;
    int          n;

    vecs[0] = '{prec: 4'd4, w: 4'b1011, act: 16'h3C00, p_eff: 4'd4, n_valid: 4, bits: 4'b1011,
                acc: 32'h0000_1234, exp: 5'd7};
    vecs[1] = '{prec: 4'd2, w: 4'b0110, act: 16'hC200, p_eff: 4'd2, n_valid: 2, bits: 4'b0010,
                acc: 32'hDEAD_BEEF, exp: 5'd30};
    vecs[2] = '{prec: 4'd0, w: 4'b0101, act: 16'h4500, p_eff: 4'd4, n_valid: 4, bits: 4'b0101,
                acc: 32'h0000_0001, exp: 5'd1};
    vecs[3] = '{prec: 4'd7, w: 4'b1110, act: 16'h7BFF, p_eff: 4'd4, n_valid: 4, bits: 4'b1110,
                acc: 32'h8000_0000, exp: 5'd31};
    vecs[4] = '{prec: 4'd1, w: 4'b0001, act: 16'h0001, p_eff: 4'd1, n_valid: 1, bits: 4'b0001,
                acc: 32'h0000_00AA, exp: 5'd2};
    vecs[5] = '{prec: 4'd3, w: 4'b1100, act: 16'hABCD, p_eff: 4'd3, n_valid: 3, bits: 4'b0100,
                acc: 32'h1357_9BDF, exp: 5'd17};
    accs[0] = 32'h10; accs[1] = 32'h25; accs[2] = 32'h3A;

    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_precision = '0; in_valid = 1'b0;
    in_act = '0; in_w = '0; mac_done = 1'b0; mac_exp_out = '0; mac_acc_out = '0;
    res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    foreach (vecs[i]) run_single(vecs[i]);

    // Zero-length job goes straight to OUT with cleared results.
    start = 1'b1; cfg_len = 8'd0; cfg_precision = 4'd4;
    tick();
    start = 1'b0;
    check("len0_res_valid", res_valid, 1'b1);
    check("len0_res", {res_exp, res_acc, err}, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("len0_idle", busy, 1'b0);

    // Three-element chain; spurious mac_done in LOAD must be ignored.
    start = 1'b1; cfg_len = 8'd3; cfg_precision = 4'd4;
    tick();
    start = 1'b0;
    prev_acc = '0;
    prev_exp = '0;
    for (int e = 0; e < 3; e++) begin
      check("chain_ready", in_ready, 1'b1);
      mac_done = 1'b1; mac_acc_out = 32'hFF; mac_exp_out = 5'h1F;
      in_valid = 1'b1; in_w = 4'(e + 1); in_act = 16'(16'h100 + e);
      tick();
      in_valid = 1'b0; mac_done = 1'b0;
      check("chain_mac_acc", mac_acc, prev_acc);
      check("chain_mac_exp_set", mac_exp_set, prev_exp);
      n = 0;
      for (int i = 0; i < 4; i++) begin
        if (mac_valid) n++;
        tick();
      end
      check("chain_valid_cycles", n, 4);
      check("chain_wait_no_valid", mac_valid, 1'b0);
      mac_done = 1'b1; mac_acc_out = accs[e]; mac_exp_out = 5'(e + 1);
      tick();
      mac_done = 1'b0;
      prev_acc = accs[e];
      prev_exp = 5'(e + 1);
    end

    // Back-pressure on the result; start during OUT is ignored.
    for (int i = 0; i < 5; i++) begin
      check("stall_res_valid", res_valid, 1'b1);
      check("stall_res_acc", res_acc, 32'h3A);
      if (i == 2) begin
        start = 1'b1; cfg_len = 8'd0;
      end
      tick();
      start = 1'b0;
    end
    check("chain_res_exp", res_exp, 5'd3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (res_valid || busy) n++;
      tick();
    end
    check("chain_single_result", n, 0);

    // Reset during FEED of the second element.
    start = 1'b1; cfg_len = 8'd2; cfg_precision = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_act = 16'h1234; in_w = 4'hF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    mac_done = 1'b1; mac_acc_out = 32'h77; mac_exp_out = 5'd5;
    tick();
    mac_done = 1'b0;
    in_valid = 1'b1; in_act = 16'h5678;
    tick();
    in_valid = 1'b0;
    check("rst_pre_feed", mac_valid, 1'b1);
    check("rst_pre_acc", mac_acc, 32'h77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midjob_rst");
    run_single(vecs[0]);

    // Watchdog: mac_done never arrives.
    start = 1'b1; cfg_len = 8'd1; cfg_precision = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_w = 4'h9;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
`ifdef FP_INT_MAC_CTRL_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 200) begin
      n++;
      tick();
    end
    check("timeout_wait_cycles", n, 64);
    check("timeout_err", err, 1'b1);
    check("timeout_res_acc", res_acc, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("timeout_cleared", {err, busy}, 2'b00);
`else
    repeat (100) tick();
    check("no_timeout_busy", busy, 1'b1);
    check("no_timeout_res_valid", res_valid, 1'b0);
    check("no_timeout_err", err, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("no_timeout_rst", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_int_mac_ctrl.md
FP_INT_MAC_CTRL -- requirements
Module: fp_int_mac_ctrl

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 16, activation width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, accumulator width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, element-count width.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports clk and rst; no other clock or reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  job start pulse; cfg_* sampled here.
REQ-008 cfg_len  in  LEN_WIDTH  number of (act, w) elements in the job.
REQ-009 cfg_precision  in  4  weight bits per element.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 in_valid / in_ready  in / out  1 each  element stream handshake.
REQ-012 in_act  in  ACT_WIDTH  fp16 activation; in_w  in  4  integer weight.
REQ-013 mac_valid, mac_w  out  1 each  MAC strobe and serial weight bit.
REQ-014 mac_act  out  ACT_WIDTH; mac_precision  out  4; mac_exp_set  out  5; mac_acc  out  32  MAC operands.
REQ-015 mac_exp_out  in  5; mac_acc_out  in  32; mac_done  in  1  MAC results.
REQ-016 res_valid / res_ready  out / in  1 each  result handshake.
REQ-017 res_exp  out  5; res_acc  out  ACC_WIDTH; err  out  1  job result and error flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, FEED, WAIT, OUT.
REQ-019 IDLE: start=1 latches cfg_len and effective precision P, then goes to LOAD; start in any other state is ignored.
REQ-020 P SHALL be cfg_precision when 1..4, else 4.
REQ-021 cfg_len=0 SHALL go IDLE->OUT directly with res_exp=0, res_acc=0, err=0.
REQ-022 in_ready SHALL be 1 only in LOAD; an element is accepted on in_valid&&in_ready, latching in_act and in_w, and moving to FEED.
REQ-023 FEED: element accepted in cycle t -> mac_valid=1 in cycles t+1..t+P, mac_w = in_w[k] in cycle t+1+k (LSB first), mac_act, mac_precision=P held stable; then WAIT.
REQ-024 mac_exp_set/mac_acc SHALL be 0 for the first element of a job, else the values captured at the previous mac_done.
REQ-025 WAIT: on mac_done=1 capture mac_exp_out/mac_acc_out, decrement remaining count; if remaining>0 go LOAD, else go OUT.
REQ-026 mac_done outside WAIT SHALL be ignored.
REQ-027 OUT: res_valid=1, res_exp/res_acc = last captured values (mac_acc_out zero-extended or truncated to ACC_WIDTH); held stable until res_ready; on handshake go IDLE.
REQ-028 mac_valid SHALL be 0 in every state except FEED.

Reset
REQ-029 rst=1 at any clock edge, including mid-job, SHALL force IDLE and drive busy, in_ready, mac_valid, mac_w, res_valid, err to 0 and mac_act, mac_precision, mac_exp_set, mac_acc, res_exp, res_acc to 0 in the next cycle; partial job discarded.

Configuration
REQ-030 Macro FP_INT_MAC_CTRL_TIMEOUT_EN SHALL enable a 6-bit watchdog counting WAIT cycles, cleared on WAIT entry.
REQ-031 With macro: 64 consecutive WAIT cycles without mac_done -> OUT with err=1, res_* = last captured values; err cleared on leaving OUT.
REQ-032 Without macro: no watchdog, WAIT unbounded, err tied 0.

Verification
REQ-033 cfg_len=1, P=4, in_w=4'b1011: mac_w sequence 1,1,0,1 over 4 mac_valid cycles; mac_exp_set=0, mac_acc=0.
REQ-034 cfg_len=3, mac_done returns acc 0x10, 0x25, 0x3A: second/third elements see mac_acc 0x10/0x25; res_acc=0x3A, single res_valid.
REQ-035 cfg_precision=0 and 7: exactly 4 mac_valid cycles per element.
REQ-036 res_ready low for 5 cycles: res_valid and res_acc stable; start pulsed during OUT ignored.
REQ-037 rst asserted in FEED of element 2: next cycle all outputs 0, state IDLE; fresh job then runs correctly.
REQ-038 With FP_INT_MAC_CTRL_TIMEOUT_EN, mac_done never asserted: res_valid and err=1 after 64 WAIT cycles; without macro, busy stays 1.
